// File: rtl/sram_arb_pkg.sv
// ----------------------------------------------------------------------------
// sram_arb_pkg
//   Shared types and constants for the two-master SRAM arbiter.
//   - arb_state_e : arbiter FSM states (idle, waiting for ACK, bubble)
//   - arb_mst_e   : master identifier (M0 = instruction fetch, M1 = LSU)
//   - SRAM_WR_LAT / SRAM_RD_LAT : controller latency from issue to ACK
//   - access_lat() : latency of an access given its write flag
// ----------------------------------------------------------------------------
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } arb_mst_e;

    localparam int SRAM_WR_LAT = 2;
    localparam int SRAM_RD_LAT = 3;

    function automatic int access_lat(input logic wren);
        return wren ? SRAM_WR_LAT : SRAM_RD_LAT;
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// ----------------------------------------------------------------------------
// sram_arb_pick
//   Combinational winner select for the two-master SRAM arbiter.
//   Build option: SRAM_ARB_RR_EN
//     defined   : round-robin, a tie goes to the master that did not win last
//     undefined : fixed priority, M1 (LSU) wins every tie
//   Ports:
//     req     in  2  request vector {M1, M0}
//     rr_last in  1  last granted master (round-robin build only)
//     grant   out 1  selected master; meaningful only when req != 0
// ----------------------------------------------------------------------------
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef SRAM_ARB_RR_EN
    input  arb_mst_e   rr_last,
`endif
    output arb_mst_e   grant
);

    always_comb begin
        grant = MST_M0;
        case (req)
            2'b01:   grant = MST_M0;
            2'b10:   grant = MST_M1;
            2'b11: begin
`ifdef SRAM_ARB_RR_EN
                grant = (rr_last == MST_M1) ? MST_M0 : MST_M1;
`else
                grant = MST_M1;
`endif
            end
            default: grant = MST_M0;
        endcase
    end

endmodule

// File: rtl/sram_arbiter_2m.sv
// ----------------------------------------------------------------------------
// sram_arbiter_2m
//   Shares one ACK-terminated 32-bit SRAM controller between two masters
//   (M0 = instruction fetch, M1 = load/store unit). One access is in flight
//   at a time; the ACK and read data are routed back to the owning master.
//   Build option: SRAM_ARB_RR_EN (round-robin ties; fixed M1 priority when
//   undefined).
//   Ports:
//     i_clk, i_reset           clock (rising edge), async active-low reset
//     i_mX_req/wren/addr/wdata/bmask   master X request and its payload
//     o_mX_ack, o_mX_rdata     master X completion pulse and read data
//     o_ADDR/o_WDATA/o_BMASK   address, write data, byte enables to controller
//     o_WREN/o_RDEN            one-cycle write / read strobe to controller
//     i_RDATA, i_ACK           read data and completion from controller
// ----------------------------------------------------------------------------
module sram_arbiter_2m
    import sram_arb_pkg::*;
#(
    parameter int AW = 18,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,

    input  logic          i_m0_req,
    input  logic          i_m0_wren,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    input  logic [3:0]    i_m0_bmask,
    output logic          o_m0_ack,
    output logic [DW-1:0] o_m0_rdata,

    input  logic          i_m1_req,
    input  logic          i_m1_wren,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    input  logic [3:0]    i_m1_bmask,
    output logic          o_m1_ack,
    output logic [DW-1:0] o_m1_rdata,

    output logic [AW-1:0] o_ADDR,
    output logic [DW-1:0] o_WDATA,
    output logic [3:0]    o_BMASK,
    output logic          o_WREN,
    output logic          o_RDEN,
    input  logic [DW-1:0] i_RDATA,
    input  logic          i_ACK
);

    arb_state_e    state;
    arb_state_e    state_nxt;
    arb_mst_e      owner;
    arb_mst_e      winner;

    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    bmask_q;

    logic          win_wren;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic [3:0]    win_bmask;

    logic [1:0]    req;
    logic          issue;

    assign req = {i_m1_req, i_m0_req};

`ifdef SRAM_ARB_RR_EN
    arb_mst_e rr_last;

    sram_arb_pick u_pick (
        .req     (req),
        .rr_last (rr_last),
        .grant   (winner)
    );
`else
    sram_arb_pick u_pick (
        .req   (req),
        .grant (winner)
    );
`endif

    // An access is launched only from idle. Gating with the reset input keeps
    // the strobes and address lines quiet while reset is held, even though
    // the masters may already be requesting.
    assign issue = i_reset & (state == ARB_IDLE) & (|req);

    // Payload of the winning master.
    always_comb begin
        if (winner == MST_M1) begin
            win_wren  = i_m1_wren;
            win_addr  = i_m1_addr;
            win_wdata = i_m1_wdata;
            win_bmask = i_m1_bmask;
        end else begin
            win_wren  = i_m0_wren;
            win_addr  = i_m0_addr;
            win_wdata = i_m0_wdata;
            win_bmask = i_m0_bmask;
        end
    end

    // State, owner and the held payload. The payload is captured at issue so
    // the controller sees stable lines for the rest of the access.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state   <= ARB_IDLE;
            owner   <= MST_M0;
            addr_q  <= '0;
            wdata_q <= '0;
            bmask_q <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                owner   <= winner;
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
                bmask_q <= win_bmask;
            end
        end
    end

`ifdef SRAM_ARB_RR_EN
    // Last granted master; starts as M1 so the first tie goes to M0.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rr_last <= MST_M1;
        end else if (issue) begin
            rr_last <= winner;
        end
    end
`endif

    // Next state and outputs. Strobes are only ever high in the issue cycle;
    // the controller re-arms in its ACK state, so keeping them low while
    // waiting prevents a second access. The DONE bubble gives the owner one
    // edge to drop its request before arbitration runs again.
    always_comb begin
        state_nxt  = state;
        o_WREN     = 1'b0;
        o_RDEN     = 1'b0;
        o_ADDR     = addr_q;
        o_WDATA    = wdata_q;
        o_BMASK    = bmask_q;
        o_m0_ack   = 1'b0;
        o_m1_ack   = 1'b0;
        o_m0_rdata = '0;
        o_m1_rdata = '0;

        case (state)
            ARB_IDLE: begin
                if (issue) begin
                    o_WREN    = win_wren;
                    o_RDEN    = ~win_wren;
                    o_ADDR    = win_addr;
                    o_WDATA   = win_wdata;
                    o_BMASK   = win_bmask;
                    state_nxt = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (i_ACK) begin
                    if (owner == MST_M1) begin
                        o_m1_ack   = 1'b1;
                        o_m1_rdata = i_RDATA;
                    end else begin
                        o_m0_ack   = 1'b1;
                        o_m0_rdata = i_RDATA;
                    end
                    state_nxt = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule
